qam16_mapper: RTL and testbench

Serial-to-symbol mapper sitting directly downstream of the `Adat_Gen` data generator in the QAM transmit chain. It collects the generator's serial bit stream (`adat_ki`, qualified by the `data_change` strobe) into 4-bit groups. Each group is Gray-mapped to a signed 16-QAM I/Q amplitude pair and buffered in a small FIFO. The modulator/filter stage drains the FIFO through a valid/ready handshake.

---
 rtl/qam_pkg.sv | 32 +++
 rtl/sym_fifo.sv | 57 +++++
 rtl/qam16_mapper.sv | 96 +++++++++
 tb/tb_qam16_mapper.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared 16-QAM definitions: symbol width and the Gray-pair to amplitude-level table.
// The demapper uses the same table.
package qam_pkg;

  localparam int unsigned BITS_PER_SYM = 4;

  // Levels are in units of LEVEL: -3, -1, +1 or +3.
  typedef struct packed {
    logic signed [2:0] i;
    logic signed [2:0] q;
  } qam_sym_t;

  function automatic logic signed [2:0] gray_to_level(input logic [1:0] g);
    logic signed [2:0] lvl;
    unique case (g)
      2'b00:   lvl = -3'sd3;
      2'b01:   lvl = -3'sd1;
      2'b11:   lvl =  3'sd1;
      default: lvl =  3'sd3;
    endcase
    return lvl;
  endfunction

  // I comes from the first two bits received, Q from the last two.
  function automatic qam_sym_t map_nibble(input logic [BITS_PER_SYM-1:0] nib);
    qam_sym_t s;
    s.i = gray_to_level(nib[3:2]);
    s.q = gray_to_level(nib[1:0]);
    return s;
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// First-word-fall-through symbol FIFO with simultaneous push/pop.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sym_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("sym_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head is read out
  // combinationally this cycle and overwritten at the edge.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/qam16_mapper.sv
// Collects strobed serial bits into 4-bit groups, Gray-maps each group to a signed
// 16-QAM I/Q pair and buffers it for a valid/ready consumer.
module qam16_mapper
  import qam_pkg::*;
#(
  parameter int AMP_W      = 8,
  parameter int LEVEL      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    data_in,
  input  logic                    data_change,
  input  logic                    align,
  input  logic                    sym_ready,
  output logic                    sym_valid,
  output logic signed [AMP_W-1:0] i_out,
  output logic signed [AMP_W-1:0] q_out,
  output logic                    overflow
);

  if ((AMP_W < 3) || (LEVEL < 1) || (3 * LEVEL > 2 ** (AMP_W - 1) - 1)) begin : g_param_check
    $error("qam16_mapper: 3*LEVEL must fit in a signed AMP_W sample");
  end

  logic [1:0]              cnt_q, cnt_d;
  logic [2:0]              shreg_q, shreg_d;
  logic                    overflow_q;
  logic                    push_req;
  logic [BITS_PER_SYM-1:0] nibble;
  qam_sym_t                lvl;
  logic signed [AMP_W-1:0] i_map, q_map;
  logic [2*AMP_W-1:0]      fifo_dout;
  logic                    fifo_full, fifo_empty, pop;

  // align overrides collection; a strobed bit in the same cycle starts the new group.
  always_comb begin
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    push_req = 1'b0;
    nibble   = {shreg_q, data_in};
    if (align) begin
      cnt_d   = '0;
      shreg_d = '0;
      if (data_change) begin
        cnt_d   = 2'd1;
        shreg_d = {2'b00, data_in};
      end
    end else if (data_change) begin
      shreg_d = {shreg_q[1:0], data_in};
      if (cnt_q == 2'd3) begin
        push_req = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  assign lvl   = map_nibble(nibble);
  assign i_map = AMP_W'(int'($signed(lvl.i)) * LEVEL);
  assign q_map = AMP_W'(int'($signed(lvl.q)) * LEVEL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      shreg_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  sym_fifo #(
    .WIDTH (2 * AMP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push_req),
    .data_i  ({i_map, q_map}),
    .pop_i   (sym_ready),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign sym_valid = ~fifo_empty;
  assign pop       = sym_valid & sym_ready;
  assign i_out     = fifo_dout[2*AMP_W-1:AMP_W];
  assign q_out     = fifo_dout[AMP_W-1:0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_qam16_mapper.sv
// Directed scoreboard bench for qam16_mapper (AMP_W=8, LEVEL=32, FIFO_DEPTH=4).
module tb_qam16_mapper;

  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset, data_in, data_change, align, sym_ready;
  logic              sym_valid, overflow;
  logic signed [7:0] i_out, q_out;

  always #5 clock = ~clock;

  qam16_mapper #(
    .AMP_W      (8),
    .LEVEL      (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .data_change (data_change),
    .align       (align),
    .sym_ready   (sym_ready),
    .sym_valid   (sym_valid),
    .i_out       (i_out),
    .q_out       (q_out),
    .overflow    (overflow)
  );

  int         tests = 0;
  int         fails = 0;
  logic [3:0] sbq[$];
  int         m_cnt;
  logic [2:0] m_bits;
  logic       m_ovf;

  function automatic int lvl(input logic [1:0] g);
    case (g)
      2'b00:   return -96;
      2'b01:   return -32;
      2'b11:   return 32;
      default: return 96;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Drive one cycle of inputs, check outputs before the edge, then advance the model.
  task automatic step(input logic dc, input logic b, input logic al, input logic rdy);
    logic       pop, push;
    logic [3:0] nib;
    data_change = dc; data_in = b; align = al; sym_ready = rdy;
    @(negedge clock);
    chk("sym_valid", {7'b0, sym_valid}, {7'b0, sbq.size() != 0});
    chk("overflow", {7'b0, overflow}, {7'b0, m_ovf});
    if (sbq.size() != 0) begin
      chk("i_head", i_out, 8'(lvl(sbq[0][3:2])));
      chk("q_head", q_out, 8'(lvl(sbq[0][1:0])));
    end else begin
      chk("i_empty", i_out, 8'd0);
      chk("q_empty", q_out, 8'd0);
    end
    pop  = (sbq.size() != 0) && rdy;
    push = 1'b0;
    nib  = '0;
    if (al) begin
      m_cnt  = dc ? 1 : 0;
      m_bits = dc ? {2'b00, b} : 3'b000;
    end else if (dc) begin
      if (m_cnt == 3) begin
        nib   = {m_bits, b};
        push  = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_bits = {m_bits[1:0], b};
    end
    if (pop) void'(sbq.pop_front());
    if (push) begin
      if (sbq.size() < DEPTH) sbq.push_back(nib);
      else m_ovf = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic send_nib(input logic [3:0] n, input logic rdy, input int gap);
    for (int k = 3; k >= 0; k--) begin
      step(1'b1, n[k], 1'b0, rdy);
      if (gap > 0) idle(gap, rdy);
    end
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any edge.
  task automatic do_reset();
    data_change = 1'b0; data_in = 1'b0; align = 1'b0; sym_ready = 1'b0;
    reset = 1'b0;
    #2;
    chk("rst_valid", {7'b0, sym_valid}, 8'd0);
    chk("rst_i", i_out, 8'd0);
    chk("rst_q", q_out, 8'd0);
    chk("rst_overflow", {7'b0, overflow}, 8'd0);
    sbq.delete();
    m_cnt = 0; m_bits = '0; m_ovf = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; data_change = 1'b0; data_in = 1'b0; align = 1'b0; sym_ready = 1'b0;
    m_cnt = 0; m_bits = '0; m_ovf = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();
    idle(2, 1'b1);

    // Single symbol 1011 -> (+96, +32), valid for exactly one cycle.
    send_nib(4'b1011, 1'b1, 0);
    idle(3, 1'b1);

    // All sixteen nibbles with varying strobe spacing.
    for (int n = 0; n < 16; n++) send_nib(4'(n), 1'b1, n % 3);
    idle(3, 1'b1);

    // Full FIFO with the completing strobe coinciding with a pop.
    send_nib(4'b0001, 1'b0, 0);
    send_nib(4'b0111, 1'b0, 1);
    send_nib(4'b1110, 1'b0, 0);
    send_nib(4'b1000, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // Realign mid-group: two bits discarded, then 1,0,0,1 -> (+96, -32).
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Align on the completing bit suppresses the push.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    send_nib(4'b1100, 1'b1, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Five symbols into a depth-4 FIFO: fifth dropped, overflow sticks.
    send_nib(4'b0010, 1'b0, 0);
    send_nib(4'b0101, 1'b0, 1);
    send_nib(4'b1001, 1'b0, 0);
    send_nib(4'b1111, 1'b0, 0);
    send_nib(4'b0100, 1'b0, 0);
    idle(2, 1'b0);
    idle(6, 1'b1);
    send_nib(4'b0011, 1'b1, 0);
    idle(3, 1'b1);

    // Reset with two symbols queued and three bits collected.
    do_reset();
    send_nib(4'b1100, 1'b0, 0);
    send_nib(4'b0011, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    send_nib(4'b0110, 1'b1, 0);
    idle(3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
